// File: rtl/clk_switch_ctrl.sv
// Glitch-safe sequencer for the 4:1 PLL clock mux select and its output clock gate.
// Order of a switch: gate off, drain, move select, settle, gate on; aborts if the target PLL loses lock.
module clk_switch_ctrl #(
   parameter int GATE_OFF_CYC = 4,
   parameter int SETTLE_CYC   = 8
) (
   input  logic       clk_i,
   input  logic       arst_ni,
   input  logic [3:0] pll_lock_i,
   input  logic       req_valid_i,
   input  logic [1:0] req_sel_i,
   input  logic       req_en_i,
   output logic       req_ready_o,
   output logic [1:0] sel_o,
   output logic       en_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o
);

   localparam int MAX_CYC = (GATE_OFF_CYC > SETTLE_CYC) ? GATE_OFF_CYC : SETTLE_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] GATE_LOAD   = CW'(GATE_OFF_CYC - 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, SETTLE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [1:0]    tgt_sel, tgt_sel_nx;
   logic          tgt_en, tgt_en_nx;
   logic [1:0]    sel_nx;
   logic          en_nx, done_nx, err_nx;
   logic          accept, req_locked, tgt_lost;

   assign accept      = req_valid_i && (state == IDLE);
   assign req_locked  = pll_lock_i[req_sel_i];
   assign tgt_lost    = !pll_lock_i[tgt_sel];
   assign req_ready_o = (state == IDLE);
   assign busy_o      = !req_ready_o;

   // Async reset closes the gate immediately, independent of the reference clock.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state   <= IDLE;
         cnt     <= '0;
         sel_o   <= '0;
         en_o    <= 1'b0;
         done_o  <= 1'b0;
         err_o   <= 1'b0;
         tgt_sel <= '0;
         tgt_en  <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         sel_o   <= sel_nx;
         en_o    <= en_nx;
         done_o  <= done_nx;
         err_o   <= err_nx;
         tgt_sel <= tgt_sel_nx;
         tgt_en  <= tgt_en_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (accept && req_locked && (req_sel_i != sel_o))
               state_nx = en_o ? DRAIN : SETTLE;
         end
         DRAIN: begin
            if (tgt_lost)         state_nx = IDLE;
            else if (cnt == '0)   state_nx = SETTLE;
         end
         SETTLE: begin
            if (tgt_lost || (cnt == '0)) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Lock loss beats the cnt==0 transition: an unlocked target never gets its gate opened.
   always_comb begin
      cnt_nx     = cnt;
      sel_nx     = sel_o;
      en_nx      = en_o;
      done_nx    = 1'b0;
      err_nx     = 1'b0;
      tgt_sel_nx = tgt_sel;
      tgt_en_nx  = tgt_en;
      unique case (state)
         IDLE: begin
            if (accept) begin
               tgt_sel_nx = req_sel_i;
               tgt_en_nx  = req_en_i;
               if (!req_locked) begin
                  err_nx = 1'b1;
               end else if (req_sel_i == sel_o) begin
                  en_nx   = req_en_i;
                  done_nx = 1'b1;
               end else if (en_o) begin
                  en_nx  = 1'b0;
                  cnt_nx = GATE_LOAD;
               end else begin
                  sel_nx = req_sel_i;
                  cnt_nx = SETTLE_LOAD;
               end
            end
         end
         DRAIN: begin
            if (tgt_lost) begin
               en_nx  = 1'b0;
               err_nx = 1'b1;
            end else if (cnt == '0) begin
               sel_nx = tgt_sel;
               cnt_nx = SETTLE_LOAD;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         SETTLE: begin
            if (tgt_lost) begin
               en_nx  = 1'b0;
               err_nx = 1'b1;
            end else if (cnt == '0) begin
               en_nx   = tgt_en;
               done_nx = 1'b1;
            end else begin
               cnt_nx = cnt - CW'(1);
            end
         end
         default: ;
      endcase
   end

   a_gate_closed_on_switch: assert property (@(posedge clk_i) disable iff (!arst_ni)
      (sel_o != $past(sel_o)) |-> !en_o);
   a_done_err_excl: assert property (@(posedge clk_i) disable iff (!arst_ni)
      !(done_o && err_o));

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Scoreboard bench for clk_switch_ctrl: each accepted request pushes its expected
// completion (done/err, sel, en, cycle); the pulse monitor pops and compares.
module tb_clk_switch_ctrl;
   localparam int G = 4;
   localparam int S = 8;

   logic       clk_i = 1'b0;
   logic       arst_ni = 1'b0;
   logic [3:0] pll_lock_i = 4'hF;
   logic       req_valid_i = 1'b0;
   logic [1:0] req_sel_i = 2'd0;
   logic       req_en_i = 1'b0;
   logic       req_ready_o, en_o, busy_o, done_o, err_o;
   logic [1:0] sel_o;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   typedef struct {
      logic       kind;   // 1 = err pulse, 0 = done pulse
      logic [1:0] sel;
      logic       en;
      int         due;
   } exp_t;
   exp_t       sb[$];
   exp_t       mon_e;
   logic [1:0] prev_sel = 2'd0;
   logic [1:0] m_sel = 2'd0;
   logic       m_en = 1'b0;

   clk_switch_ctrl #(.GATE_OFF_CYC(G), .SETTLE_CYC(S)) dut (
      .clk_i(clk_i), .arst_ni(arst_ni), .pll_lock_i(pll_lock_i),
      .req_valid_i(req_valid_i), .req_sel_i(req_sel_i), .req_en_i(req_en_i),
      .req_ready_o(req_ready_o), .sel_o(sel_o), .en_o(en_o), .busy_o(busy_o),
      .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk_i) begin
      if (arst_ni) begin
         chk("gate_vs_sel", 32'(en_o && (sel_o != prev_sel)), 32'(0));
         chk("done_err_excl", 32'(done_o && err_o), 32'(0));
         if (done_o || err_o) begin
            if (sb.size() == 0) begin
               chk("unexp_pulse", 32'({done_o, err_o}), 32'(0));
            end else begin
               mon_e = sb.pop_front();
               chk("kind", 32'(err_o), 32'(mon_e.kind));
               chk("sel", 32'(sel_o), 32'(mon_e.sel));
               chk("en", 32'(en_o), 32'(mon_e.en));
               chk("due", 32'(cyc), 32'(mon_e.due));
            end
         end
      end
      prev_sel = sel_o;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic k, input logic [1:0] s, input logic e, input int due);
      exp_t x;
      x.kind = k; x.sel = s; x.en = e; x.due = due;
      sb.push_back(x);
   endtask

   task automatic accept(input logic [1:0] s, input logic e, output int acc);
      int n = 0;
      while (!req_ready_o && n < 100) begin
         tick();
         n++;
      end
      chk("ready_wait", 32'(req_ready_o), 32'(1));
      req_valid_i = 1'b1;
      req_sel_i   = s;
      req_en_i    = e;
      tick();
      req_valid_i = 1'b0;
      acc = cyc;
   endtask

   // Predicts the outcome from the bench's own view of sel/en and the lock flags.
   task automatic req(input logic [1:0] s, input logic e);
      int acc, lat;
      logic k, xe;
      logic [1:0] xs;
      if (!pll_lock_i[s]) begin
         k = 1'b1; lat = 0; xs = m_sel; xe = m_en;
      end else if (s == m_sel) begin
         k = 1'b0; lat = 0; xs = s; xe = e;
      end else begin
         k = 1'b0; lat = m_en ? G + S : S; xs = s; xe = e;
      end
      accept(s, e, acc);
      push(k, xs, xe, acc + lat);
      m_sel = xs;
      m_en  = xe;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         chk("timeout", 32'(sb.size()), 32'(0));
         sb.delete();
      end
   endtask

   task automatic mid_reset(input string tag);
      #2 arst_ni = 1'b0;
      #1;
      chk({tag, "_en"}, 32'(en_o), 32'(0));
      chk({tag, "_sel"}, 32'(sel_o), 32'(0));
      chk({tag, "_rdy"}, 32'(req_ready_o), 32'(1));
      chk({tag, "_busy"}, 32'(busy_o), 32'(0));
      sb.delete();
      m_sel = 2'd0;
      m_en  = 1'b0;
      @(negedge clk_i);
      #1 arst_ni = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_sel", 32'(sel_o), 32'(0));
      chk("rst_en", 32'(en_o), 32'(0));
      chk("rst_rdy", 32'(req_ready_o), 32'(1));
      chk("rst_busy", 32'(busy_o), 32'(0));
      chk("rst_done", 32'(done_o), 32'(0));
      chk("rst_err", 32'(err_o), 32'(0));
      @(negedge clk_i);
      #1 arst_ni = 1'b1;
      tick();

      // Gate off switch to 2: select moves at T+1, gate opens at T+S+1.
      req(2'd2, 1'b1);
      chk("t1_sel", 32'(sel_o), 32'(2));
      chk("t1_en", 32'(en_o), 32'(0));
      chk("t1_busy", 32'(busy_o), 32'(1));
      wait_idle();

      // Gate on switch to 1: select holds until T+G+1 with the gate closed.
      req(2'd1, 1'b1);
      chk("t2_en_fall", 32'(en_o), 32'(0));
      repeat (G - 1) tick();
      chk("t2_sel_old", 32'(sel_o), 32'(2));
      tick();
      chk("t2_sel_new", 32'(sel_o), 32'(1));
      chk("t2_en_low", 32'(en_o), 32'(0));
      wait_idle();

      // Unlocked target is refused without leaving IDLE.
      pll_lock_i[3] = 1'b0;
      req(2'd3, 1'b1);
      chk("t3_rdy", 32'(req_ready_o), 32'(1));
      wait_idle();
      pll_lock_i[3] = 1'b1;

      // Lock lost mid-SETTLE.
      req(2'd1, 1'b0);
      wait_idle();
      accept(2'd2, 1'b1, acc);
      repeat (3) tick();
      pll_lock_i[2] = 1'b0;
      push(1'b1, 2'd2, 1'b0, acc + 4);
      wait_idle();
      chk("t4_rdy", 32'(req_ready_o), 32'(1));
      pll_lock_i[2] = 1'b1;
      m_sel = 2'd2; m_en = 1'b0;

      // Lock lost on the cnt==0 cycle of SETTLE: abort wins over done.
      accept(2'd0, 1'b1, acc);
      repeat (S - 1) tick();
      pll_lock_i[0] = 1'b0;
      push(1'b1, 2'd0, 1'b0, acc + S);
      wait_idle();
      repeat (3) tick();
      pll_lock_i[0] = 1'b1;
      m_sel = 2'd0; m_en = 1'b0;

      // Same-source gate toggles, back to back.
      req(2'd0, 1'b1);
      req(2'd0, 1'b0);
      req(2'd0, 1'b1);
      wait_idle();
      chk("t5_sel", 32'(sel_o), 32'(0));

      // Lock lost mid-DRAIN: select never moves.
      accept(2'd3, 1'b1, acc);
      tick();
      pll_lock_i[3] = 1'b0;
      push(1'b1, 2'd0, 1'b0, acc + 2);
      wait_idle();
      pll_lock_i[3] = 1'b1;
      m_sel = 2'd0; m_en = 1'b0;

      // Reset with the gate open in IDLE.
      req(2'd2, 1'b1);
      wait_idle();
      chk("t6_en_on", 32'(en_o), 32'(1));
      mid_reset("rst_idle");

      // Reset mid-DRAIN.
      req(2'd1, 1'b1);
      wait_idle();
      accept(2'd3, 1'b1, acc);
      repeat (2) tick();
      mid_reset("rst_drain");

      // Reset mid-SETTLE.
      accept(2'd2, 1'b1, acc);
      repeat (3) tick();
      mid_reset("rst_settle");

      // Normal completion after reset.
      req(2'd3, 1'b1);
      chk("t7_sel", 32'(sel_o), 32'(3));
      wait_idle();
      chk("t7_en", 32'(en_o), 32'(1));
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/clk_switch_ctrl.md
# clk_switch_ctrl

Control-side sequencer for the clock-reset generator's 4:1 PLL clock mux and output clock gate. It accepts clock-source and gate requests on a valid/ready interface and drives the mux select and gate enable in a glitch-safe order: gate off, drain, switch select, settle, gate on. It runs on an always-on reference clock, independent of the PLL clocks it switches. It also refuses, or aborts, any switch to a PLL that is not locked.

## Interface
- GATE_OFF_CYC, default 4: cycles held with en_o low before sel_o changes; legal range ≥1.
- SETTLE_CYC, default 8: cycles between the sel_o change and en_o re-assertion; legal range ≥1.
- clk_i  in  1  always-on reference clock; every register is on its rising edge.
- arst_ni  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronized upstream.
- pll_lock_i  in  4  per-PLL lock flags, already synchronous to clk_i.
- req_valid_i  in  1  request valid.
- req_sel_i  in  2  target PLL index.
- req_en_i  in  1  gate state wanted after the request completes.
- req_ready_o  out  1  high only in IDLE.
- sel_o  out  2  drives the mux select.
- en_o  out  1  drives the clock-gate enable.
- busy_o  out  1  equals !req_ready_o.
- done_o  out  1  one-cycle pulse when a request completes.
- err_o  out  1  one-cycle pulse on a rejected or aborted request.

## Operation
- Reset values: sel_o=0, en_o=0, req_ready_o=1, busy_o=0, done_o=0, err_o=0, state=IDLE, counter=0.
- Reset assertion forces en_o low immediately, without waiting for a clock edge.
- State IDLE; a request is accepted on req_valid_i && req_ready_o. req_sel_i and req_en_i are latched internally as tgt_sel and tgt_en. The first matching rule applies:
  - Target not locked (pll_lock_i[req_sel_i]=0): err_o=1 next cycle; sel_o and en_o unchanged; stay IDLE.
  - req_sel_i == sel_o: en_o<=req_en_i, done_o=1 next cycle; stay IDLE.
  - en_o==1: en_o<=0, cnt<=GATE_OFF_CYC-1, go to DRAIN.
  - en_o==0: sel_o<=req_sel_i, cnt<=SETTLE_CYC-1, go to SETTLE.
- State DRAIN: decrement cnt each cycle. When cnt==0: sel_o<=tgt_sel, cnt<=SETTLE_CYC-1, go to SETTLE.
- State SETTLE: decrement cnt each cycle. When cnt==0: en_o<=tgt_en, done_o<=1, go to IDLE.
- Abort: if pll_lock_i[tgt_sel]==0 in any cycle of DRAIN or SETTLE, then at the next edge go to IDLE with en_o<=0 and err_o<=1. sel_o keeps its current value; no done_o is issued.
- Abort has priority over the cnt==0 transition in the same cycle.
- en_o is never 1 in any cycle in which sel_o differs from its value in the previous cycle.
- req_valid_i is ignored outside IDLE. No queueing: the requester holds valid until it sees ready.
- Counter width is $clog2(max(GATE_OFF_CYC, SETTLE_CYC)+1). The counter never wraps: it is always reloaded before reaching 0 is exceeded.

## Timing
All outputs are registered. Let T be the acceptance cycle; G=GATE_OFF_CYC, S=SETTLE_CYC.
- Change while gate on:
  - en_o=0 from T+1.
  - sel_o=new at T+G+1.
  - en_o=tgt_en and done_o at T+G+S+1.
  - req_ready_o=1 at T+G+S+1.
- Change while gate off: sel_o=new at T+1; en_o and done_o at T+S+1.
- Same source: en_o updated and done_o at T+1.
- Unlocked target: err_o at T+1.
- Back-to-back: a new request may be accepted in the same cycle done_o or err_o is high.
- done_o and err_o are never high in the same cycle.

## Test plan
- Reset, then request sel=2, en=1 with all locks high → sel_o=2 at T+1; en_o=1 and done_o at T+9 (gate was off, S=8).
- From (sel=2, en=1), request sel=1, en=1 → en_o falls at T+1; sel_o=1 at T+5; en_o=1 and done_o at T+13. Check that en_o is low through the sel_o change.
- Request sel=3 with pll_lock_i[3]=0 → err_o pulse at T+1; sel_o and en_o unchanged; req_ready_o stays 1.
- Drop pll_lock_i[target] during SETTLE, and again on the cnt==0 cycle → err_o next cycle, en_o=0, IDLE, no done_o.
- Request the same sel with en=0, then en=1 → en_o toggles at T+1 each time with a done_o pulse; sel_o stable.
- Assert arst_ni mid-DRAIN and mid-SETTLE → en_o=0 with no clock edge; after release sel_o=0, req_ready_o=1, and a new request completes normally.
